// File: rtl/max_pool.sv
// 2x2 signed max pooling over a streamed multi-channel CNN feature map.
// Optional MAX_POOL_RELU_CLAMP_EN clamps negative pooled channels to zero.
module max_pool #(
    parameter int WIDTH     = 4,
    parameter int HEIGHT    = 4,
    parameter int W_WIDTH   = 8,
    parameter int W_HEIGHT  = 8,
    parameter int INT_BITW  = 4,
    parameter int FRAC_BITW = 4,
    parameter int UNITS     = 1,
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
    localparam int V_BITW     = $clog2(W_HEIGHT),
    localparam int H_BITW     = $clog2(W_WIDTH)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          in_enable,
    input  logic [FIXED_BITW*UNITS-1:0]   in_pixels,
    input  logic [V_BITW-1:0]             in_vcnt,
    input  logic [H_BITW-1:0]             in_hcnt,
    output logic                          out_enable,
    output logic [FIXED_BITW*UNITS-1:0]   out_pixels,
    output logic [V_BITW-1:0]             out_vcnt,
    output logic [H_BITW-1:0]             out_hcnt
);

    localparam int PW     = FIXED_BITW * UNITS;
    localparam int DEPTH  = WIDTH / 2;
    localparam int A_BITW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [H_BITW:0] LP_W = (H_BITW+1)'(WIDTH);
    localparam logic [V_BITW:0] LP_H = (V_BITW+1)'(HEIGHT);

    function automatic logic [PW-1:0] f_max(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b
    );
        logic [PW-1:0] r;
        r = '0;
        for (int p = 0; p < UNITS; p++) begin
            if ($signed(a[p*FIXED_BITW +: FIXED_BITW]) >
                $signed(b[p*FIXED_BITW +: FIXED_BITW]))
                r[p*FIXED_BITW +: FIXED_BITW] = a[p*FIXED_BITW +: FIXED_BITW];
            else
                r[p*FIXED_BITW +: FIXED_BITW] = b[p*FIXED_BITW +: FIXED_BITW];
        end
        return r;
    endfunction

    logic              w_valid;
    logic              w_even_row;
    logic              w_pair_done;
    logic [A_BITW-1:0] w_addr;
    logic [PW-1:0]     w_pmax;
    logic [PW-1:0]     w_fin;

    logic [PW-1:0]     r_hold;
    logic              r_pair_vld;
    logic              r_row_vld;
    logic              r_row_arm;
    logic [PW-1:0]     r_lbuf [DEPTH];

    logic              r_s1_vld;
    logic [PW-1:0]     r_s1_pmax;
    logic [PW-1:0]     r_s1_buf;
    logic [V_BITW-1:0] r_s1_vcnt;
    logic [H_BITW-1:0] r_s1_hcnt;

    logic              r_out_en;
    logic [PW-1:0]     r_out_pix;
    logic [V_BITW-1:0] r_out_vcnt;
    logic [H_BITW-1:0] r_out_hcnt;

    assign w_valid     = in_enable
                       & ({1'b0, in_hcnt} < LP_W)
                       & ({1'b0, in_vcnt} < LP_H);
    assign w_even_row  = ~in_vcnt[0];
    assign w_pair_done = w_valid & in_hcnt[0] & r_pair_vld;
    assign w_addr      = A_BITW'(in_hcnt >> 1);
    assign w_pmax      = f_max(r_hold, in_pixels);

    // Line buffer holds even-row pair maxima; never reset, gated by row-valid.
    always_ff @(posedge clock) begin
        if (!rst && w_pair_done && w_even_row)
            r_lbuf[w_addr] <= w_pmax;
    end

    // Row-valid is only re-armed once an even row starts after reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_hold     <= '0;
            r_pair_vld <= 1'b0;
            r_row_vld  <= 1'b0;
            r_row_arm  <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_pmax  <= '0;
            r_s1_buf   <= '0;
            r_s1_vcnt  <= '0;
            r_s1_hcnt  <= '0;
        end else begin
            r_s1_vld <= 1'b0;
            if (w_valid) begin
                if (!in_hcnt[0]) begin
                    r_hold     <= in_pixels;
                    r_pair_vld <= 1'b1;
                end else if (r_pair_vld) begin
                    r_pair_vld <= 1'b0;
                    if (w_even_row) begin
                        if (r_row_arm)
                            r_row_vld <= 1'b1;
                    end else if (r_row_vld) begin
                        r_s1_vld  <= 1'b1;
                        r_s1_pmax <= w_pmax;
                        r_s1_buf  <= r_lbuf[w_addr];
                        r_s1_vcnt <= in_vcnt >> 1;
                        r_s1_hcnt <= in_hcnt >> 1;
                    end
                end
                if (w_even_row && in_hcnt == '0) begin
                    r_row_vld <= 1'b0;
                    r_row_arm <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_fin = f_max(r_s1_buf, r_s1_pmax);
`ifdef MAX_POOL_RELU_CLAMP_EN
        for (int p = 0; p < UNITS; p++) begin
            if (w_fin[p*FIXED_BITW + FIXED_BITW - 1])
                w_fin[p*FIXED_BITW +: FIXED_BITW] = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_out_en   <= 1'b0;
            r_out_pix  <= '0;
            r_out_vcnt <= '0;
            r_out_hcnt <= '0;
        end else begin
            r_out_en <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_pix  <= w_fin;
                r_out_vcnt <= r_s1_vcnt;
                r_out_hcnt <= r_s1_hcnt;
            end
        end
    end

    assign out_enable = r_out_en;
    assign out_pixels = r_out_pix;
    assign out_vcnt   = r_out_vcnt;
    assign out_hcnt   = r_out_hcnt;

endmodule

// File: tb/tb_max_pool.sv
// Directed bench for max_pool: one UNITS=1 and one UNITS=3 instance.
// Expected clamped values apply when MAX_POOL_RELU_CLAMP_EN is defined.
module tb_max_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        en1, oe1;
    logic [7:0]  pix1, op1;
    logic [2:0]  v1, h1, ov1, oh1;
    logic        en3, oe3;
    logic [23:0] pix3, op3;
    logic [2:0]  v3, h3, ov3, oh3;

    max_pool #(
        .WIDTH(4), .HEIGHT(4), .W_WIDTH(8), .W_HEIGHT(8),
        .INT_BITW(4), .FRAC_BITW(4), .UNITS(1)
    ) u_dut1 (
        .clock(clk), .rst(rst),
        .in_enable(en1), .in_pixels(pix1), .in_vcnt(v1), .in_hcnt(h1),
        .out_enable(oe1), .out_pixels(op1), .out_vcnt(ov1), .out_hcnt(oh1)
    );

    max_pool #(
        .WIDTH(4), .HEIGHT(4), .W_WIDTH(8), .W_HEIGHT(8),
        .INT_BITW(4), .FRAC_BITW(4), .UNITS(3)
    ) u_dut3 (
        .clock(clk), .rst(rst),
        .in_enable(en3), .in_pixels(pix3), .in_vcnt(v3), .in_hcnt(h3),
        .out_enable(oe3), .out_pixels(op3), .out_vcnt(ov3), .out_hcnt(oh3)
    );

    typedef struct {
        int          cyc;
        logic [23:0] pix;
        logic [2:0]  v;
        logic [2:0]  h;
    } rec_t;

    rec_t q1[$];
    rec_t q3[$];
    int   dc[$];
    int   img[4][4];

    always @(negedge clk) begin
        if (oe1) q1.push_back('{cyc, {16'h0, op1}, ov1, oh1});
        if (oe3) q3.push_back('{cyc, op3, ov3, oh3});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en1 = 1'b0;
            en3 = 1'b0;
        end
    endtask

    task automatic drv1(input int v, input int h, input int p);
        @(negedge clk);
        en1 = 1'b1; v1 = 3'(v); h1 = 3'(h); pix1 = 8'(p);
        en3 = 1'b0;
    endtask

    task automatic drv3(input int v, input int h,
                        input int c0, input int c1, input int c2);
        @(negedge clk);
        en3 = 1'b1; v3 = 3'(v); h3 = 3'(h);
        pix3 = {8'(c2), 8'(c1), 8'(c0)};
        en1 = 1'b0;
    endtask

    task automatic rows1(input int r0, input int r1);
        for (int v = r0; v <= r1; v++)
            for (int h = 0; h < 4; h++) begin
                drv1(v, h, img[v][h]);
                if ((v % 2 == 1) && (h % 2 == 1)) dc.push_back(cyc);
            end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        tests++; if (oe1 !== 1'b0) begin fails++; $display("FAIL reset_oe1: got %0b want 0", oe1); end
        tests++; if (op1 !== 8'h00) begin fails++; $display("FAIL reset_op1: got %0h want 0", op1); end
        tests++; if ({ov1, oh1} !== 6'h00) begin fails++; $display("FAIL reset_coord1: got %0h want 0", {ov1, oh1}); end
        tests++; if (oe3 !== 1'b0) begin fails++; $display("FAIL reset_oe3: got %0b want 0", oe3); end
        tests++; if (op3 !== 24'h0) begin fails++; $display("FAIL reset_op3: got %0h want 0", op3); end
        tests++; if ({ov3, oh3} !== 6'h00) begin fails++; $display("FAIL reset_coord3: got %0h want 0", {ov3, oh3}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int ev[4]  = '{6, 8, 14, 16};
        int evv[4] = '{0, 0, 1, 1};
        int evh[4] = '{0, 1, 0, 1};
        q1.delete(); dc.delete();
        img = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};
        rows1(0, 3);
        idle(4);
        tests++; if (q1.size() !== 4) begin fails++; $display("FAIL basic_count: got %0d want 4", q1.size()); end
        for (int i = 0; i < 4 && i < q1.size(); i++) begin
            tests++; if (q1[i].pix[7:0] !== 8'(ev[i])) begin fails++; $display("FAIL basic_val%0d: got %0d want %0d", i, q1[i].pix[7:0], ev[i]); end
            tests++; if ({q1[i].v, q1[i].h} !== {3'(evv[i]), 3'(evh[i])}) begin fails++; $display("FAIL basic_coord%0d: got (%0d,%0d) want (%0d,%0d)", i, q1[i].v, q1[i].h, evv[i], evh[i]); end
            tests++; if (q1[i].cyc !== dc[i] + 2) begin fails++; $display("FAIL basic_lat%0d: got %0d want %0d", i, q1[i].cyc - dc[i], 2); end
        end
        tests++; if (op1 !== 8'd16 || oe1 !== 1'b0) begin fails++; $display("FAIL basic_hold: got %0d/%0b want 16/0", op1, oe1); end
    endtask

    task automatic test_blanking;
        q1.delete();
        for (int v = 0; v < 4; v++)
            for (int h = 4; h < 8; h++) drv1(v, h, 'h7F);
        for (int v = 4; v < 8; v++)
            for (int h = 0; h < 8; h++) drv1(v, h, 'h7F);
        idle(4);
        tests++; if (q1.size() !== 0) begin fails++; $display("FAIL blank_count: got %0d want 0", q1.size()); end
        tests++; if (op1 !== 8'd16) begin fails++; $display("FAIL blank_val: got %0h want 10", op1); end
        tests++; if ({ov1, oh1} !== 6'b001_001) begin fails++; $display("FAIL blank_coord: got (%0d,%0d) want (1,1)", ov1, oh1); end
    endtask

    task automatic test_negative;
`ifdef MAX_POOL_RELU_CLAMP_EN
        int ev[2] = '{0, 0};
`else
        int ev[2] = '{-1, -4};
`endif
        q1.delete(); dc.delete();
        img[0] = '{-3, -1, -4, -7};
        img[1] = '{-8, -2, -6, -5};
        rows1(0, 1);
        idle(4);
        tests++; if (q1.size() !== 2) begin fails++; $display("FAIL neg_count: got %0d want 2", q1.size()); end
        for (int i = 0; i < 2 && i < q1.size(); i++) begin
            tests++; if (q1[i].pix[7:0] !== 8'(ev[i])) begin fails++; $display("FAIL neg_val%0d: got %0h want %0h", i, q1[i].pix[7:0], 8'(ev[i])); end
            tests++; if ({q1[i].v, q1[i].h, 1'b0} !== {3'd0, 3'(i), 1'b0} || q1[i].cyc !== dc[i] + 2) begin fails++; $display("FAIL neg_pos%0d: got (%0d,%0d)@%0d want (0,%0d)@%0d", i, q1[i].v, q1[i].h, q1[i].cyc, i, dc[i] + 2); end
        end
    endtask

    task automatic test_rst_midframe;
        q1.delete(); dc.delete();
        img = '{'{10, -20, 30, 5}, '{7, 8, -1, 40}, '{-9, 3, 50, 2}, '{-4, -10, 1, 49}};
        for (int h = 0; h < 4; h++) drv1(0, h, img[0][h]);
        drv1(1, 0, img[1][0]);
        @(negedge clk);
        en1 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (op1 !== 8'h00 || oe1 !== 1'b0) begin fails++; $display("FAIL mid_rst_out: got %0h/%0b want 0/0", op1, oe1); end
        tests++; if ({ov1, oh1} !== 6'h00) begin fails++; $display("FAIL mid_rst_coord: got %0h want 0", {ov1, oh1}); end
        for (int h = 1; h < 4; h++) drv1(1, h, img[1][h]);
        idle(3);
        tests++; if (q1.size() !== 0) begin fails++; $display("FAIL mid_row1_quiet: got %0d want 0", q1.size()); end
        rows1(2, 3);
        idle(4);
        tests++; if (q1.size() !== 2) begin fails++; $display("FAIL mid_count: got %0d want 2", q1.size()); end
        if (q1.size() >= 2) begin
            tests++; if (q1[0].pix[7:0] !== 8'd3 || {q1[0].v, q1[0].h} !== 6'b001_000) begin fails++; $display("FAIL mid_p0: got %0d (%0d,%0d) want 3 (1,0)", q1[0].pix[7:0], q1[0].v, q1[0].h); end
            tests++; if (q1[1].pix[7:0] !== 8'd50 || {q1[1].v, q1[1].h} !== 6'b001_001) begin fails++; $display("FAIL mid_p1: got %0d (%0d,%0d) want 50 (1,1)", q1[1].pix[7:0], q1[1].v, q1[1].h); end
            tests++; if (q1[0].cyc !== dc[0] + 2 || q1[1].cyc !== dc[1] + 2) begin fails++; $display("FAIL mid_lat: got %0d,%0d want 2,2", q1[0].cyc - dc[0], q1[1].cyc - dc[1]); end
        end
    endtask

    task automatic test_gap;
        int c0, c1;
        q1.delete();
        drv1(0, 0, 20); idle(3); drv1(0, 1, 25);
        drv1(0, 2, 1); drv1(0, 3, 2);
        drv1(1, 0, 30); idle(3); drv1(1, 1, 4); c0 = cyc;
        drv1(1, 2, -3); drv1(1, 3, 7); c1 = cyc;
        idle(4);
        tests++; if (q1.size() !== 2) begin fails++; $display("FAIL gap_count: got %0d want 2", q1.size()); end
        if (q1.size() >= 2) begin
            tests++; if (q1[0].pix[7:0] !== 8'd30 || q1[0].cyc !== c0 + 2) begin fails++; $display("FAIL gap_p0: got %0d lat %0d want 30 lat 2", q1[0].pix[7:0], q1[0].cyc - c0); end
            tests++; if (q1[1].pix[7:0] !== 8'd7 || q1[1].cyc !== c1 + 2) begin fails++; $display("FAIL gap_p1: got %0d lat %0d want 7 lat 2", q1[1].pix[7:0], q1[1].cyc - c1); end
        end
    endtask

    task automatic test_units;
        logic [23:0] e0, e1;
        int c0, c1;
        e0 = 24'h00_05_05;
`ifdef MAX_POOL_RELU_CLAMP_EN
        e1 = 24'h00_02_03;
`else
        e1 = 24'hFD_02_03;
`endif
        q3.delete();
        drv3(0, 0, 5, -5, 0);  drv3(0, 1, -5, 5, 0);
        drv3(0, 2, -1, 2, -3); drv3(0, 3, 3, -2, -4);
        drv3(1, 0, 1, -7, -3); drv3(1, 1, -2, 4, 0); c0 = cyc;
        drv3(1, 2, 0, 0, -5);  drv3(1, 3, -9, 1, -6); c1 = cyc;
        idle(4);
        tests++; if (q3.size() !== 2) begin fails++; $display("FAIL units_count: got %0d want 2", q3.size()); end
        if (q3.size() >= 2) begin
            tests++; if (q3[0].pix !== e0 || q3[0].cyc !== c0 + 2) begin fails++; $display("FAIL units_p0: got %0h lat %0d want %0h lat 2", q3[0].pix, q3[0].cyc - c0, e0); end
            tests++; if (q3[1].pix !== e1 || {q3[1].v, q3[1].h} !== 6'b000_001) begin fails++; $display("FAIL units_p1: got %0h (%0d,%0d) want %0h (0,1)", q3[1].pix, q3[1].v, q3[1].h, e1); end
            tests++; if (q3[1].cyc !== c1 + 2) begin fails++; $display("FAIL units_lat1: got %0d want 2", q3[1].cyc - c1); end
        end
        tests++; if (q1.size() !== 0) begin fails++; $display("FAIL units_isolation: got %0d want 0", q1.size()); end
    endtask

    initial begin
        rst = 1'b1;
        en1 = 1'b0; pix1 = '0; v1 = '0; h1 = '0;
        en3 = 1'b0; pix3 = '0; v3 = '0; h3 = '0;
        test_reset();
        test_basic();
        test_blanking();
        test_negative();
        test_rst_midframe();
        q1.delete();
        test_gap();
        q1.delete();
        test_units();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
